// File: rtl/clk_switch_pkg.sv
// Shared types and sizing helpers for the clock-switch controller.
package clk_switch_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BREAK_WAIT = 2'd1,
        MAKE_WAIT  = 2'd2
    } clk_sw_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_IDX = 2'd1,
        ERR_DEAD    = 2'd2,
        ERR_LOST    = 2'd3
    } clk_sw_err_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter only ever holds (window - 1), so clog2 of the larger window suffices.
    function automatic int cnt_width(input int off_c, input int on_c);
        int m;
        m = max2(off_c, on_c);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clk_switch_timer.sv
// Loadable down-counter shared by the break and make settle windows.
module clk_switch_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Break-before-make sequencer driving the one-hot select of a glitch-free clock mux.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int NUM_CLOCKS  = 4,
    parameter int DEFAULT_SEL = 0,
    parameter int OFF_CYCLES  = 8,
    parameter int ON_CYCLES   = 8,
    localparam int SEL_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [SEL_W-1:0]      req_sel,
    output logic                  req_ready,
    input  logic [NUM_CLOCKS-1:0] clk_alive,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic                  switch_done,
    output logic                  switch_err,
    output logic [1:0]            err_code
);

    localparam int                    CNT_W    = cnt_width(OFF_CYCLES, ON_CYCLES);
    localparam logic [CNT_W-1:0]      OFF_LD   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]      ON_LD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [NUM_CLOCKS-1:0] SEL_ONE  = NUM_CLOCKS'(1);
    localparam logic [NUM_CLOCKS-1:0] DEF_OH   = SEL_ONE << DEFAULT_SEL;
    localparam logic [SEL_W-1:0]      DEF_IDX  = SEL_W'(DEFAULT_SEL);
    localparam logic [SEL_W:0]        NUM_IDX  = (SEL_W+1)'(NUM_CLOCKS);

    clk_sw_state_e         r_state, w_state;
    logic [NUM_CLOCKS-1:0] r_select, w_select;
    logic [SEL_W-1:0]      r_cur, w_cur;
    logic [SEL_W-1:0]      r_tgt, w_tgt;
    logic                  r_done, w_done;
    logic                  r_err, w_err;
    clk_sw_err_e           r_code, w_code;
    logic                  w_load;
    logic [CNT_W-1:0]      w_load_val;
    logic                  w_zero;
    logic                  w_bad_idx;
    logic                  w_req_alive;
    logic                  w_tgt_lost;

    clk_switch_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    assign w_bad_idx   = ({1'b0, req_sel} >= NUM_IDX);
    assign w_req_alive = w_bad_idx ? 1'b0 : clk_alive[req_sel];
    assign w_tgt_lost  = !clk_alive[r_tgt];

    always_comb begin
        w_state    = r_state;
        w_select   = r_select;
        w_cur      = r_cur;
        w_tgt      = r_tgt;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_code     = ERR_NONE;
        w_load     = 1'b0;
        w_load_val = OFF_LD;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_bad_idx) begin
                        w_err  = 1'b1;
                        w_code = ERR_BAD_IDX;
                    end else if (!w_req_alive) begin
                        w_err  = 1'b1;
                        w_code = ERR_DEAD;
                    end else if (req_sel == r_cur) begin
                        w_done = 1'b1;
                    end else begin
                        w_tgt    = req_sel;
                        w_select = '0;
                        w_load   = 1'b1;
                        w_state  = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                if (w_zero) begin
                    w_select   = SEL_ONE << r_tgt;
                    w_load     = 1'b1;
                    w_load_val = ON_LD;
                    w_state    = MAKE_WAIT;
                end
            end
            MAKE_WAIT: begin
                // A dying default has nowhere to fall back to, so it only reports.
                if (w_tgt_lost && (r_tgt != DEF_IDX)) begin
                    w_select = '0;
                    w_tgt    = DEF_IDX;
                    w_load   = 1'b1;
                    w_state  = BREAK_WAIT;
                    w_err    = 1'b1;
                    w_code   = ERR_LOST;
                end else if (w_zero) begin
                    w_cur   = r_tgt;
                    w_done  = 1'b1;
                    w_state = IDLE;
                end else if (w_tgt_lost) begin
                    w_err  = 1'b1;
                    w_code = ERR_LOST;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_select <= DEF_OH;
            r_cur    <= DEF_IDX;
            r_tgt    <= DEF_IDX;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
        end else begin
            r_state  <= w_state;
            r_select <= w_select;
            r_cur    <= w_cur;
            r_tgt    <= w_tgt;
            r_done   <= w_done;
            r_err    <= w_err;
            r_code   <= w_code;
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign busy        = !req_ready;
    assign clk_select  = r_select;
    assign cur_sel     = r_cur;
    assign switch_done = r_done;
    assign switch_err  = r_err;
    assign err_code    = r_code;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench: timeline model of the switch sequence plus directed and random stimulus.
module tb_clk_switch_ctrl;

    localparam int N   = 4;
    localparam int DEF = 0;
    localparam int OFF = 8;
    localparam int ON  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [3:0] clk_alive;
    logic [3:0] clk_select;
    logic [1:0] cur_sel;
    logic       busy, switch_done, switch_err;
    logic [1:0] err_code;

    logic       req_valid3;
    logic [1:0] req_sel3;
    logic       req_ready3;
    logic [2:0] clk_alive3;
    logic [2:0] clk_select3;
    logic [1:0] cur_sel3;
    logic       busy3, done3, err3;
    logic [1:0] err_code3;

    int n_chk = 0;
    int n_fail = 0;

    // Model: a switch is a timeline anchored at its start cycle m_s.
    int   m_cyc, m_s, m_tgt, m_cur;
    bit   m_act;
    bit   e_done, e_err;
    int   e_code;
    bit   chk_en = 1'b0;
    logic [3:0] p_sel;

    always #5 clk = ~clk;

    clk_switch_ctrl #(.NUM_CLOCKS(N), .DEFAULT_SEL(DEF), .OFF_CYCLES(OFF), .ON_CYCLES(ON)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .clk_alive(clk_alive), .clk_select(clk_select), .cur_sel(cur_sel), .busy(busy),
        .switch_done(switch_done), .switch_err(switch_err), .err_code(err_code)
    );

    clk_switch_ctrl #(.NUM_CLOCKS(3), .DEFAULT_SEL(0), .OFF_CYCLES(OFF), .ON_CYCLES(ON)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_sel(req_sel3), .req_ready(req_ready3),
        .clk_alive(clk_alive3), .clk_select(clk_select3), .cur_sel(cur_sel3), .busy(busy3),
        .switch_done(done3), .switch_err(err3), .err_code(err_code3)
    );

    function automatic logic [3:0] onehot(input int i);
        return 4'(1) << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_sel();
        if (!m_act) return onehot(m_cur);
        return (m_cyc <= m_s + OFF) ? 4'b0000 : onehot(m_tgt);
    endfunction

    task automatic model_reset();
        m_act = 0; m_cur = DEF; m_tgt = DEF; m_s = 0; m_cyc = 0;
        e_done = 0; e_err = 0; e_code = 0;
        p_sel = onehot(DEF);
    endtask

    // Advance the model across one clock edge using the inputs seen in the cycle just ended.
    task automatic model_edge(input bit rv, input int rs, input logic [3:0] al);
        bit lost;
        e_done = 0; e_err = 0; e_code = 0;
        if (!m_act) begin
            if (rv) begin
                if (rs >= N) begin e_err = 1; e_code = 1; end
                else if (!al[rs]) begin e_err = 1; e_code = 2; end
                else if (rs == m_cur) e_done = 1;
                else begin m_act = 1; m_s = m_cyc; m_tgt = rs; end
            end
        end else if (m_cyc > m_s + OFF) begin
            lost = !al[m_tgt];
            if (lost && m_tgt != DEF) begin
                e_err = 1; e_code = 3; m_s = m_cyc; m_tgt = DEF;
            end else if (m_cyc == m_s + OFF + ON) begin
                e_done = 1; m_cur = m_tgt; m_act = 0;
            end else if (lost) begin
                e_err = 1; e_code = 3;
            end
        end
        m_cyc++;
    endtask

    task automatic step(input bit rv, input logic [1:0] rs, input logic [3:0] al);
        req_valid = rv; req_sel = rs; clk_alive = al;
        @(posedge clk);
        model_edge(rv, int'(rs), al);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'd3, 4'hf);
    endtask

    // Compare process: every mid-cycle, DUT outputs against the model and the select invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                check("clk_select", 32'(clk_select), 32'(exp_sel()));
                check("cur_sel", 32'(cur_sel), 32'(m_cur));
                check("req_ready", 32'(req_ready), 32'(!m_act));
                check("busy", 32'(busy), 32'(m_act));
                check("switch_done", 32'(switch_done), 32'(e_done));
                check("switch_err", 32'(switch_err), 32'(e_err));
                if (e_err) check("err_code", 32'(err_code), 32'(e_code));
                check("select_onehot0", 32'($onehot0(clk_select)), 32'(1));
                check("no_oh_to_oh", 32'($onehot(p_sel) && $onehot(clk_select) && (p_sel != clk_select)), 32'(0));
                p_sel = clk_select;
            end
        end
    end

    initial begin
        logic [3:0] al;
        req_valid = 0; req_sel = 0; clk_alive = 4'hf;
        req_valid3 = 0; req_sel3 = 0; clk_alive3 = 3'b111;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        // 1: reset state
        check("rst_select", 32'(clk_select), 32'h1);
        check("rst_cur", 32'(cur_sel), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_pulses", 32'({switch_done, switch_err}), 32'h0);
        step(1'b0, 2'd0, 4'hf);

        // 2: switch to 2, requests while busy must be ignored
        step(1'b1, 2'd2, 4'hf);
        check("t2_sel_T1", 32'(clk_select), 32'h0);
        check("t2_busy_T1", 32'(busy), 32'h1);
        idle_steps(7);
        check("t2_sel_T8", 32'(clk_select), 32'h0);
        idle_steps(1);
        check("t2_sel_T9", 32'(clk_select), 32'h4);
        idle_steps(7);
        check("t2_busy_T16", 32'(busy), 32'h1);
        step(1'b0, 2'd0, 4'hf);
        check("t2_done_T17", 32'(switch_done), 32'h1);
        check("t2_cur_T17", 32'(cur_sel), 32'h2);
        check("t2_ready_T17", 32'(req_ready), 32'h1);

        // back to 0, then the no-op request on the committed index
        step(1'b1, 2'd0, 4'hf);
        for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 4'hf);
        step(1'b1, 2'd0, 4'hf);
        check("t3_noop_done", 32'(switch_done), 32'h1);
        check("t3_noop_sel", 32'(clk_select), 32'h1);

        // 3b: out-of-range index on a 3-clock build
        req_valid3 = 1'b1; req_sel3 = 2'd3;
        step(1'b0, 2'd0, 4'hf);
        req_valid3 = 1'b0;
        check("t3_bad_err", 32'(err3), 32'h1);
        check("t3_bad_code", 32'(err_code3), 32'h1);
        check("t3_bad_sel", 32'(clk_select3), 32'h1);

        // 4: dead target
        step(1'b1, 2'd2, 4'b1011);
        check("t4_err", 32'(switch_err), 32'h1);
        check("t4_code", 32'(err_code), 32'h2);
        check("t4_sel", 32'(clk_select), 32'h1);

        // 5: target 3 dies during the make window
        step(1'b1, 2'd3, 4'hf);
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 4'hf);
        step(1'b0, 2'd0, 4'b0111);
        check("t5_err_T12", 32'(switch_err), 32'h1);
        check("t5_code_T12", 32'(err_code), 32'h3);
        check("t5_sel_T12", 32'(clk_select), 32'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 2'd0, 4'hf);
        check("t5_sel_T19", 32'(clk_select), 32'h0);
        step(1'b0, 2'd0, 4'hf);
        check("t5_sel_T20", 32'(clk_select), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 4'hf);
        check("t5_done_T28", 32'(switch_done), 32'h1);
        check("t5_cur_T28", 32'(cur_sel), 32'h0);

        // 6: asynchronous reset mid-switch
        step(1'b1, 2'd1, 4'hf);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 4'hf);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_sel", 32'(clk_select), 32'h1);
        check("t6_async_busy", 32'(busy), 32'h0);
        check("t6_async_cur", 32'(cur_sel), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd1, 4'hf);
        check("t6_accept", 32'(busy), 32'h1);
        for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 4'hf);
        check("t6_done", 32'(switch_done), 32'h1);
        check("t6_cur", 32'(cur_sel), 32'h1);

        // random traffic with occasional source dropouts
        for (int i = 0; i < 3000; i++) begin
            al = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf;
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), al);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
